seg7_reader: RTL and testbench

Captures the state of a multiplexed, common-cathode 7-segment display bus and recovers the BCD digits it shows, the inverse of the team's BCD-to-segment driver. Each candidate digit pattern must hold steady for a programmable number of cycles before it is accepted, which filters multiplex transitions and ghosting. Once every digit position has been captured, the block presents one packed BCD frame with a single-cycle valid strobe. It sits on the loopback/self-test path next to the display driver and on external display-scraping inputs.

---
 rtl/seg7_reader.sv | 108 ++++++++++
 tb/tb_seg7_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// Seven-segment bus reader: debounces multiplexed digit samples, decodes them to BCD
// and emits one packed frame once every digit position has been captured.
module seg7_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              segments,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    valid,
    output logic                    frame_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [4*NUM_DIGITS-1:0] digits_nxt;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   seen_nxt;
    logic                    err;
    logic                    err_nxt;
    logic                    onehot;
    logic                    same;
    logic                    cap;
    logic                    frame_done;
    logic [3:0]              code;
    logic                    bad;

    always_comb begin
        code = 4'hE;
        bad  = 1'b0;
        unique case (seg_q)
            7'b0111111: code = 4'h0;
            7'b0000110: code = 4'h1;
            7'b1011011: code = 4'h2;
            7'b1001111: code = 4'h3;
            7'b1100110: code = 4'h4;
            7'b1101101: code = 4'h5;
            7'b1111100: code = 4'h6;
            7'b0000111: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1100111: code = 4'h9;
            7'b0000000: code = 4'hF;
            default:    bad  = 1'b1;
        endcase
    end

    always_comb begin
        onehot = $onehot(digit_sel);
        same   = (segments == seg_q) && (digit_sel == sel_q);
        cnt_nxt = CW'(1);
        if (!onehot)
            cnt_nxt = '0;
        else if (same && cnt != '0)
            cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
        // STABLE_CYCLES >= 2 guarantees CNT_PRE is nonzero, so this is the single crossing edge
        cap = onehot && same && (cnt == CNT_PRE);
    end

    always_comb begin
        frame_done = &seen;
        digits_nxt = digits;
        seen_nxt   = frame_done ? '0 : seen;
        err_nxt    = frame_done ? 1'b0 : err;
        if (cap) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
                if (sel_q[i])
                    digits_nxt[4*i +: 4] = code;
            seen_nxt = seen_nxt | sel_q;
            err_nxt  = err_nxt | bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q     <= '0;
            sel_q     <= '0;
            cnt       <= '0;
            digits    <= '0;
            seen      <= '0;
            err       <= 1'b0;
            value     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            seg_q  <= segments;
            sel_q  <= digit_sel;
            cnt    <= cnt_nxt;
            digits <= digits_nxt;
            seen   <= seen_nxt;
            err    <= err_nxt;
            valid  <= frame_done;
            if (frame_done) begin
                value     <= digits;
                frame_err <= err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Testbench for seg7_reader: directed scenarios plus random dwell sequences checked
// against a run-length reference model of the display bus.
module tb_seg7_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    segments;
    logic [ND-1:0] digit_sel;
    logic [4*ND-1:0] value;
    logic          valid;
    logic          frame_err;

    seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .segments(segments), .digit_sel(digit_sel),
        .value(value), .valid(valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int vcount = 0;
    int last_valid_cyc = -1;

    logic [6:0] pat [11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7C, 7'h07, 7'h7F, 7'h67, 7'h00};
    logic [3:0] pcode [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                               4'h6, 4'h7, 4'h8, 4'h9, 4'hF};

    // reference model: unsaturated run length of identical one-hot samples
    logic [6:0] m_pseg;
    logic [3:0] m_psel;
    int         m_run;
    logic [3:0] m_dig [ND];
    bit         m_seen [ND];
    bit         m_err;
    logic [4*ND-1:0] m_value;
    bit         m_valid;
    bit         m_ferr;

    task automatic m_reset();
        m_pseg = '0; m_psel = '0; m_run = 0; m_err = 0;
        m_value = '0; m_valid = 0; m_ferr = 0;
        for (int i = 0; i < ND; i++) begin m_dig[i] = '0; m_seen[i] = 0; end
    endtask

    task automatic m_step(input logic [6:0] s, input logic [3:0] d);
        bit all_seen = 1;
        bit badp = 1;
        logic [3:0] c = 4'hE;
        for (int i = 0; i < ND; i++) if (!m_seen[i]) all_seen = 0;
        if ($countones(d) != 1) m_run = 0;
        else if (s == m_pseg && d == m_psel && m_run > 0) m_run++;
        else m_run = 1;
        m_valid = all_seen;
        if (all_seen) begin
            for (int i = 0; i < ND; i++) begin
                m_value[4*i +: 4] = m_dig[i];
                m_seen[i] = 0;
            end
            m_ferr = m_err;
            m_err = 0;
        end
        if (m_run == SC) begin
            for (int k = 0; k < 11; k++) if (pat[k] == s) begin c = pcode[k]; badp = 0; end
            for (int i = 0; i < ND; i++) if (d[i]) begin m_dig[i] = c; m_seen[i] = 1; end
            m_err = m_err | badp;
        end
        m_pseg = s; m_psel = d;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid", {15'd0, valid}, {15'd0, m_valid});
        chk("value", value, m_value);
        chk("frame_err", {15'd0, frame_err}, {15'd0, m_ferr});
    endtask

    task automatic cyc(input logic [6:0] s, input logic [3:0] d);
        segments = s; digit_sel = d;
        @(posedge clk);
        cyc_n++;
        m_step(s, d);
        #1;
        check_outputs();
        if (valid) begin vcount++; last_valid_cyc = cyc_n; end
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) cyc(s, d);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_value", value, 16'h0);
        chk("rst_valid", {15'd0, valid}, 16'h0);
        chk("rst_ferr", {15'd0, frame_err}, 16'h0);
        segments = '0; digit_sel = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    int st, vc0;

    initial begin
        rst_n = 1'b0; segments = '0; digit_sel = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("init_value", value, 16'h0);
        chk("init_valid", {15'd0, valid}, 16'h0);

        // frame 4,3,2,1 with latency check
        hold(7'h06, 4'b0001, 6);
        hold(7'h5B, 4'b0010, 6);
        hold(7'h4F, 4'b0100, 6);
        st = cyc_n + 1;
        hold(7'h66, 4'b1000, 6);
        chk("t1_count", 16'(vcount), 16'd1);
        chk("t1_value", value, 16'h4321);
        chk("t1_ferr", {15'd0, frame_err}, 16'h0);
        chk("t1_latency", 16'(last_valid_cyc), 16'(st + SC));

        // dropout restarts count; then a 4-cycle hold captures
        hold(7'h06, 4'b0001, 3);
        hold(7'h06, 4'b0000, 1);
        hold(7'h06, 4'b0001, 3);
        hold(7'h00, 4'b0000, 1);
        hold(7'h06, 4'b0001, 4);

        // invalid pattern at position 2
        vc0 = vcount;
        hold(7'h3F, 4'b0001, 6);
        hold(7'h7F, 4'b0010, 6);
        hold(7'h40, 4'b0100, 6);
        hold(7'h67, 4'b1000, 6);
        chk("t3_count", 16'(vcount - vc0), 16'd1);
        chk("t3_value", value, 16'h9E80);
        chk("t3_ferr", {15'd0, frame_err}, 16'h1);

        // two enables for 10 cycles, then blank at position 1
        vc0 = vcount;
        hold(7'h6D, 4'b0011, 10);
        chk("t4_multi", 16'(vcount - vc0), 16'd0);
        hold(7'h6D, 4'b0001, 6);
        hold(7'h00, 4'b0010, 6);
        hold(7'h7C, 4'b0100, 6);
        hold(7'h07, 4'b1000, 6);
        chk("t4_value", value, 16'h76F5);
        chk("t4_ferr", {15'd0, frame_err}, 16'h0);

        // long hold and mid-frame overwrite of position 0
        vc0 = vcount;
        hold(7'h4F, 4'b0001, 50);
        hold(7'h5B, 4'b0010, 6);
        hold(7'h7F, 4'b0001, 6);
        hold(7'h66, 4'b0100, 6);
        hold(7'h06, 4'b1000, 6);
        chk("t5_count", 16'(vcount - vc0), 16'd1);
        chk("t5_value", value, 16'h1428);

        // reset after three captures discards them
        hold(7'h06, 4'b0001, 6);
        hold(7'h5B, 4'b0010, 6);
        hold(7'h4F, 4'b0100, 6);
        do_reset();
        vc0 = vcount;
        hold(7'h7C, 4'b0010, 6);
        hold(7'h07, 4'b0100, 6);
        hold(7'h67, 4'b1000, 6);
        chk("t6_partial", 16'(vcount - vc0), 16'd0);
        hold(7'h3F, 4'b0001, 6);
        chk("t6_count", 16'(vcount - vc0), 16'd1);
        chk("t6_value", value, 16'h9760);

        // randomized dwells, glitches and odd enables
        for (int n = 0; n < 400; n++) begin
            int k = $urandom_range(0, 12);
            logic [6:0] s;
            logic [3:0] d;
            s = (k >= 11) ? 7'($urandom) : pat[k];
            d = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, ND - 1));
            hold(s, d, $urandom_range(1, 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
